// File: rtl/scpad_pkg.sv
// Shared scratchpad types: request payload and the scheduler's FIFO entry format.
package scpad_pkg;

  localparam int SCPAD_ID_WIDTH = 2;

  // scpad_id sits in the MSBs so routing can slice it off the flat vector.
  typedef struct packed {
    logic [SCPAD_ID_WIDTH-1:0] scpad_id;
    logic                      write;
    logic [9:0]                addr;
    logic [15:0]               wdata;
  } req_t;

  localparam int REQ_WIDTH = $bits(req_t);

  typedef struct packed {
    logic src;
    req_t req;
  } sched_entry_t;

  localparam logic SCHED_SRC_BE = 1'b0;
  localparam logic SCHED_SRC_FE = 1'b1;

endpackage

// File: rtl/scpad_sched_fifo.sv
// Generic DEPTH-entry synchronous FIFO of scheduler entries with flush.
module scpad_sched_fifo
  import scpad_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  sched_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output sched_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  sched_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/scpad_req_sched.sv
// Per-scratchpad BE/FE request scheduler: BE-priority arbitration with FE
// anti-starvation, feeding a small valid/ready output FIFO.
module scpad_req_sched
  import scpad_pkg::*;
#(
  parameter logic [SCPAD_ID_WIDTH-1:0] IDX        = '0,
  parameter int                        DEPTH      = 2,
  parameter int                        STARVE_MAX = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             be_req_valid,
  input  logic [REQ_WIDTH-1:0]             be_req,
  input  logic                             fe_req_valid,
  input  logic [REQ_WIDTH-1:0]             fe_req,
  input  logic                             w_stall,
  input  logic                             r_stall,
  input  logic                             flush,
  output logic                             be_stall,
  output logic                             fe_stall,
  output logic                             out_valid,
  output logic [REQ_WIDTH-1:0]             out_req,
  output logic                             out_src,
  input  logic                             out_ready,
  output logic [$clog2(STARVE_MAX+1)-1:0]  starve_cnt
);

  localparam int SW  = $clog2(STARVE_MAX + 1);
  localparam int FCW = $clog2(DEPTH + 1);

  logic           pop;
  logic           can_grant;
  logic           force_fe;
  logic           grant_be;
  logic           grant_fe;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  sched_entry_t   push_entry;
  sched_entry_t   head;

  assign pop = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    can_grant  = 1'b0;
    force_fe   = 1'b0;
    grant_fe   = 1'b0;
    grant_be   = 1'b0;
    push_entry = '0;
    // Gating on n_rst keeps both stalls high while reset is held.
    can_grant  = n_rst && (!fifo_full || pop) && !w_stall && !r_stall && !flush;
    force_fe   = (starve_cnt == SW'(STARVE_MAX));
    grant_fe   = can_grant && fe_req_valid && (!be_req_valid || force_fe);
    grant_be   = can_grant && be_req_valid && !grant_fe;
    if (grant_fe) begin
      push_entry.src = SCHED_SRC_FE;
      push_entry.req = fe_req;
    end else begin
      push_entry.src = SCHED_SRC_BE;
      push_entry.req = be_req;
    end
  end

  assign be_stall = !grant_be;
  assign fe_stall = !grant_fe;

  scpad_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (grant_be || grant_fe),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_req   = head.req;
  assign out_src   = head.src;

  // Saturates at STARVE_MAX and stays there until FE actually wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_cnt <= '0;
    end else if (flush || grant_fe) begin
      starve_cnt <= '0;
    end else if (grant_be && fe_req_valid && !force_fe) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Requests steered to this instance must target its own scratchpad.
  a_be_idx: assert property (@(posedge clk) disable iff (!n_rst)
    grant_be |-> (be_req[REQ_WIDTH-1 -: SCPAD_ID_WIDTH] == IDX));
  a_fe_idx: assert property (@(posedge clk) disable iff (!n_rst)
    grant_fe |-> (fe_req[REQ_WIDTH-1 -: SCPAD_ID_WIDTH] == IDX));
  a_count:  assert property (@(posedge clk) disable iff (!n_rst)
    fifo_count <= FCW'(DEPTH));

endmodule

// File: tb/tb_scpad_req_sched.sv
// Self-checking bench for scpad_req_sched: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_scpad_req_sched;
  import scpad_pkg::*;

  localparam int                        DEPTH      = 2;
  localparam int                        STARVE_MAX = 4;
  localparam logic [SCPAD_ID_WIDTH-1:0] IDX        = '0;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 be_req_valid = 1'b0;
  logic [REQ_WIDTH-1:0] be_req = '0;
  logic                 fe_req_valid = 1'b0;
  logic [REQ_WIDTH-1:0] fe_req = '0;
  logic                 w_stall = 1'b0;
  logic                 r_stall = 1'b0;
  logic                 flush = 1'b0;
  logic                 be_stall;
  logic                 fe_stall;
  logic                 out_valid;
  logic [REQ_WIDTH-1:0] out_req;
  logic                 out_src;
  logic                 out_ready = 1'b1;
  logic [2:0]           starve_cnt;

  scpad_req_sched #(.IDX(IDX), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .be_req_valid (be_req_valid),
    .be_req       (be_req),
    .fe_req_valid (fe_req_valid),
    .fe_req       (fe_req),
    .w_stall      (w_stall),
    .r_stall      (r_stall),
    .flush        (flush),
    .be_stall     (be_stall),
    .fe_stall     (fe_stall),
    .out_valid    (out_valid),
    .out_req      (out_req),
    .out_src      (out_src),
    .out_ready    (out_ready),
    .starve_cnt   (starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 src;
    logic [REQ_WIDTH-1:0] req;
  } ent_t;

  ent_t q[$];
  int   sc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   g_be, g_fe;
  logic last_be_stall, last_fe_stall;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_WIDTH-1:0] rand_req();
    logic [REQ_WIDTH-1:0] r;
    r = REQ_WIDTH'($urandom);
    r[REQ_WIDTH-1 -: SCPAD_ID_WIDTH] = IDX;
    return r;
  endfunction

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic cycle(string tag);
    bit   pop, cg, gfe, gbe;
    ent_t e;
    #2;
    pop = (q.size() > 0) && out_ready;
    cg  = n_rst && !flush && !w_stall && !r_stall && ((q.size() < DEPTH) || pop);
    gfe = cg && fe_req_valid && (!be_req_valid || sc == STARVE_MAX);
    gbe = cg && be_req_valid && !gfe;
    check({tag, ".be_stall"}, 64'(be_stall), 64'(!gbe));
    check({tag, ".fe_stall"}, 64'(fe_stall), 64'(!gfe));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    check({tag, ".out_req"}, 64'(out_req), (q.size() > 0) ? 64'(q[0].req) : 64'(0));
    check({tag, ".out_src"}, 64'(out_src), (q.size() > 0) ? 64'(q[0].src) : 64'(0));
    check({tag, ".starve_cnt"}, 64'(starve_cnt), 64'(sc));
    last_be_stall = be_stall;
    last_fe_stall = fe_stall;
    g_be = gbe;
    g_fe = gfe;
    @(posedge clk);
    if (n_rst) begin
      if (flush) begin
        q.delete();
        sc = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (gfe) begin
          e.src = 1'b1; e.req = fe_req; q.push_back(e); sc = 0;
        end else if (gbe) begin
          e.src = 1'b0; e.req = be_req; q.push_back(e);
          if (fe_req_valid && sc < STARVE_MAX) sc++;
        end
      end
    end
    @(negedge clk);
    if (g_be) be_req = rand_req();
    if (g_fe) fe_req = rand_req();
  endtask

  initial begin
    be_req = rand_req();
    fe_req = rand_req();
    @(negedge clk);

    // Reset held three cycles; BE presents a request in the last one.
    for (int i = 0; i < 3; i++) begin
      be_req_valid = (i == 2);
      cycle("reset");
      check("reset_be_stall", 64'(last_be_stall), 64'(1));
    end

    // First request after release: granted at once, visible one cycle later.
    n_rst = 1'b1;
    be_req_valid = 1'b1;
    be_req = REQ_WIDTH'(8'hA5);
    cycle("first");
    check("first_be_stall", 64'(last_be_stall), 64'(0));
    be_req_valid = 1'b0;
    check("first_out_valid", 64'(out_valid), 64'(1));
    check("first_out_req", 64'(out_req), 64'(8'hA5));
    check("first_out_src", 64'(out_src), 64'(0));

    // Both streams busy: BE x4 then a forced FE grant, repeating.
    be_req_valid = 1'b1;
    fe_req_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      cycle("prio");
      check("prio_fe_grant", 64'(!last_fe_stall), 64'(k % 5 == 4));
      check("prio_starve", 64'(starve_cnt), 64'((k % 5 == 4) ? 0 : (k % 5) + 1));
    end

    // Drain, then backpressure with BE streaming.
    be_req_valid = 1'b0;
    fe_req_valid = 1'b0;
    repeat (3) cycle("drain");
    out_ready = 1'b0;
    be_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("bp");
      check("bp_be_grant", 64'(!last_be_stall), 64'(k < 2));
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release_grant", 64'(!last_be_stall), 64'(1));
    check("bp_release_valid", 64'(out_valid), 64'(1));

    // Downstream write stall, then read stall, with both streams valid.
    fe_req_valid = 1'b1;
    w_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle("wstall");
      check("wstall_no_grant", 64'({last_be_stall, last_fe_stall}), 64'(2'b11));
    end
    w_stall = 1'b0;
    r_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle("rstall");
      check("rstall_no_grant", 64'({last_be_stall, last_fe_stall}), 64'(2'b11));
    end
    r_stall = 1'b0;

    // Flush with two queued entries and starve_cnt at 3.
    flush = 1'b1;
    cycle("pre_flush");
    flush = 1'b0;
    cycle("fill1");
    cycle("fill2");
    out_ready = 1'b0;
    cycle("fill3");
    check("flush_setup_starve", 64'(starve_cnt), 64'(3));
    flush = 1'b1;
    cycle("flush");
    check("flush_no_grant", 64'({last_be_stall, last_fe_stall}), 64'(2'b11));
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_starve", 64'(starve_cnt), 64'(0));
    out_ready = 1'b1;

    // Random traffic; requesters hold valid and payload until accepted.
    for (int k = 0; k < 400; k++) begin
      if (!be_req_valid) be_req_valid = ($urandom_range(0, 2) != 0);
      if (!fe_req_valid) fe_req_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      w_stall   = ($urandom_range(0, 9) == 0);
      r_stall   = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle("rand");
      if (g_be) be_req_valid = 1'b0;
      if (g_fe) fe_req_valid = 1'b0;
    end
    w_stall = 1'b0;
    r_stall = 1'b0;
    flush = 1'b0;

    // Mid-operation reset with out_valid=1 and starve_cnt=2.
    flush = 1'b1;
    cycle("pre_reset_flush");
    flush = 1'b0;
    out_ready = 1'b1;
    be_req_valid = 1'b1;
    fe_req_valid = 1'b1;
    cycle("pre_reset1");
    cycle("pre_reset2");
    check("midrst_setup_valid", 64'(out_valid), 64'(1));
    check("midrst_setup_starve", 64'(starve_cnt), 64'(2));
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_starve", 64'(starve_cnt), 64'(0));
    check("midrst_out_req", 64'(out_req), 64'(0));
    check("midrst_stalls", 64'({be_stall, fe_stall}), 64'(2'b11));
    q.delete();
    sc = 0;
    cycle("in_reset1");
    cycle("in_reset2");
    @(negedge clk);
    n_rst = 1'b1;

    for (int k = 0; k < 100; k++) begin
      if (!be_req_valid) be_req_valid = ($urandom_range(0, 1) != 0);
      if (!fe_req_valid) fe_req_valid = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle("post_reset");
      if (g_be) be_req_valid = 1'b0;
      if (g_fe) fe_req_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/scpad_req_sched.md
Name: scpad_req_sched

Overview:
Per-scratchpad request scheduler in front of the scratchpad controller FIFO / xbar path. It arbitrates between backend (BE) and frontend (FE) request streams: BE has priority, and an FE anti-starvation counter bounds how long FE can wait. Granted requests go into a small output FIFO with a valid/ready interface, which decouples requester stalls from downstream backpressure. One instance per scratchpad, selected by IDX.

Parameters:
IDX, '0, scratchpad ID this instance serves (width SCPAD_ID_WIDTH).
DEPTH, 2, output FIFO entries; power of 2, at least 2.
STARVE_MAX, 4, consecutive BE-won grants allowed while FE is waiting before FE is forced.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
be_req_valid  in  1  BE request valid; held with be_req until accepted
be_req  in  $bits(req_t)  BE request payload
fe_req_valid  in  1  FE request valid; held with fe_req until accepted
fe_req  in  $bits(req_t)  FE request payload
w_stall  in  1  downstream write stall; blocks new grants
r_stall  in  1  downstream read stall; blocks new grants
flush  in  1  synchronous clear of FIFO and starvation counter
be_stall  out  1  BE not accepted this cycle
fe_stall  out  1  FE not accepted this cycle
out_valid  out  1  FIFO head valid
out_req  out  $bits(req_t)  FIFO head payload
out_src  out  1  head source: 0 = BE, 1 = FE
out_ready  in  1  downstream accepts head when out_valid && out_ready
starve_cnt  out  $clog2(STARVE_MAX+1)  current starvation count (debug)

Behaviour:
- Reset: FIFO empty, out_valid=0, out_req=0, out_src=0, starve_cnt=0. be_stall=fe_stall=1 while n_rst=0.
- pop = out_valid && out_ready. space = (count < DEPTH) || pop; same-cycle pop frees a slot.
- can_grant = space && !w_stall && !r_stall && !flush.
- force_fe = (starve_cnt == STARVE_MAX).
- grant_fe = can_grant && fe_req_valid && (!be_req_valid || force_fe).
- grant_be = can_grant && be_req_valid && !grant_fe. At most one grant per cycle.
- be_stall = !grant_be; fe_stall = !grant_fe. Both are combinational. A requester holds valid and payload until its stall is low. Stall is 1 even when valid is 0.
- Push: a grant writes {src, payload} at the tail on the next clk edge. Push and pop in the same cycle leave count unchanged. Pointers wrap mod DEPTH.
- Accept-to-out_valid latency is 1 cycle. out_req/out_src come from registered FIFO storage, with no combinational path from inputs.
- starve_cnt: set to 0 on grant_fe. Increment (saturating at STARVE_MAX) on grant_be while fe_req_valid=1. Otherwise hold. It stays at STARVE_MAX until FE is granted, including across downstream stalls.
- flush: next edge empties the FIFO (count=0, pointers=0, out_valid=0) and sets starve_cnt=0. No grant is issued in the flush cycle. Any pop in that cycle is discarded.
- Full FIFO with no pop: both stalls stay 1. Contents and counter hold.
- Reset asserted mid-operation: all state clears immediately. In-flight entries are lost; requesters must re-present.

Decomposition:
- scpad_pkg holds req_t and SCPAD_ID_WIDTH (already present). It also gains new typedef sched_entry_t = {logic src; req_t req} and localparam SCHED_SRC_BE=0, SCHED_SRC_FE=1.
- Sub-module scpad_sched_fifo: generic DEPTH-entry sync FIFO of sched_entry_t with push/pop/flush, full/empty/count. The arbiter and counter stay in the top level.

Test Plan:
- Reset then idle: n_rst low 3 cycles, no valids, out_ready=1 -> out_valid=0, be_stall=fe_stall=1, starve_cnt=0. After release, be_req_valid=1 with payload 0xA5 -> be_stall=0 that cycle; next cycle out_valid=1, out_req=0xA5, out_src=0.
- Priority and starvation, STARVE_MAX=4: BE and FE valid every cycle, out_ready=1 -> grant sequence BE,BE,BE,BE,FE repeating. starve_cnt goes 1,2,3,4,0.
- Backpressure: out_ready=0, DEPTH=2, BE valid continuously -> 2 grants, then be_stall=1 steady. Raise out_ready -> one pop plus one push in the same cycle, and count stays at 2.
- Downstream stall: w_stall=1 for 3 cycles with FE and BE valid -> no grants, stalls=1, FIFO drains normally. r_stall gives the same result.
- Flush: FIFO holding 2 entries, starve_cnt=3, flush=1 for one cycle -> next cycle out_valid=0, starve_cnt=0, and no grant in the flush cycle.
- Mid-op reset: assert n_rst low while out_valid=1 and starve_cnt=2 -> outputs clear asynchronously without waiting for a clk edge.
